joypad_scanner: RTL
===================

# joypad_scanner

Autonomous, parametrised serial game-controller scanner for NUM_PORTS shift-register pads (8-bit NES or 16-bit SNES style). It generates the shared latch and clock strobes, synchronises each port's serial data, detects pad presence, and publishes a parallel active-high button image once per scan. It sits between the controller port pins and any consumer of parallel pad state: a CPU-side register file, a debug overlay, or the reset/button logic at top level.

## Interface
- NUM_PORTS, 2, number of controller ports scanned in parallel
- NUM_BITS, 8, button bits per pad (16 for SNES pads)
- CLK_DIV, 150, clk_in cycles per half serial period (6 µs at 25 MHz)
- SCAN_PERIOD, 416666, clk_in cycles between automatic scan starts; 0 disables automatic scanning
- clk_in  input  1  system clock; one clock domain
- rst_n  input  1  reset, synchronous, active-low
- scan_req_in  input  1  single-cycle request to start a scan immediately
- jp_data_in  input  NUM_PORTS  raw serial data per port; low = pressed; the top level pulls disconnected ports low
- jp_latch_out  output  1  latch strobe, active high
- jp_clk_out  output  1  shared shift clock, idle low
- buttons_out  output  NUM_PORTS*NUM_BITS  bit p*NUM_BITS+k = port p, button k pressed (k=0 shifted first)
- present_out  output  NUM_PORTS  port p has a pad connected
- valid_out  output  1  one-cycle pulse when buttons_out/present_out update
- busy_out  output  1  high from LATCH entry through DONE

## Operation
- jp_data_in passes through a 2-flop synchroniser per port; all sampling uses the synchronised value.
- FSM states and transitions:
  - IDLE: period counter decrements. On scan_req_in, or counter==0 with SCAN_PERIOD!=0, go to LATCH and reload the counter to SCAN_PERIOD-1.
  - LATCH: jp_latch_out=1 for 2*CLK_DIV cycles. Bit 0 is sampled on the last cycle. Then go to SHIFT.
  - SHIFT: NUM_BITS slots, each jp_clk_out=1 for CLK_DIV cycles then 0 for CLK_DIV cycles, with a sample on the slot's last cycle. Slots 1..NUM_BITS-1 sample button bits. Slot NUM_BITS samples the tail bit. Then go to DONE.
  - DONE: one cycle. Commit outputs, pulse valid_out, then go to IDLE.
- Presence: a connected pad shifts out 1 after its last button, so present = tail bit==1. Absent ports force their buttons_out slice to 0.
- Stored bits are inverted so that buttons_out is active-high.
- scan_req_in outside IDLE is ignored and not queued. scan_req_in coinciding with counter==0 starts one scan.
- Counters are sized with $clog2 of their maximum. Parameters must satisfy CLK_DIV>=1 and NUM_BITS>=1.

## Timing
- Reset values: all outputs 0, FSM in IDLE, period counter 0. The first automatic scan therefore starts on the first cycle after rst_n rises (when SCAN_PERIOD!=0).
- If scan_req_in is sampled high in IDLE at cycle T:
  - jp_latch_out is high for cycles T+1..T+2*CLK_DIV.
  - valid_out fires at T+2*CLK_DIV*(NUM_BITS+1)+1.
- With defaults, scan length is 2701 cycles.
- buttons_out and present_out change only in the valid_out cycle and hold between scans.
- rst_n low mid-scan: at the next edge the FSM returns to IDLE, jp_latch_out/jp_clk_out/busy_out/valid_out go to 0, and the partial shift data is discarded.

## Configuration
- JOYPAD_SCANNER_DEBOUNCE_EN defined: per port, buttons_out commits a new value only when this scan's button bits equal the previous scan's raw bits. present_out still updates every scan, and valid_out still pulses every scan.
- Not defined: every scan commits directly; no previous-scan storage is synthesised.

## Structure
- Package joypad_pkg: FSM state enum (IDLE, LATCH, SHIFT, DONE) and default timing constants for 25 MHz operation.
- Sub-module jp_port_shift, instantiated NUM_PORTS times via generate:
  - synchroniser
  - NUM_BITS+1 shift register
  - presence flag
  - optional debounce compare/history
- The top of the block holds the FSM, the period counter, the half-period divider and the bit counter.

## Test plan
Bench parameters: NUM_PORTS=2, NUM_BITS=8, CLK_DIV=2, SCAN_PERIOD=100.
- Release reset with the port model idle -> jp_latch_out high on cycles 1..4 after reset release; valid_out pulses on cycle 37; 8 jp_clk_out pulses, each 2 cycles high.
- Port0 pad model returns 0b01011010 (A first, low=pressed) then tail 1; port1 held low -> buttons_out[7:0]=8'hA5, buttons_out[15:8]=0, present_out=2'b01.
- scan_req_in pulsed during SHIFT and again in IDLE -> the first request is ignored; the second starts LATCH on the next cycle; the period counter restarts (next automatic scan 100 cycles later).
- rst_n low for one cycle mid-SHIFT -> strobes drop to 0 next cycle and outputs clear; a fresh scan starts after release.
- SCAN_PERIOD=0 -> no scans without scan_req_in; busy_out stays 0.
- JOYPAD_SCANNER_DEBOUNCE_EN defined, port0 pattern changes 0x00 -> 0x81 -> 0x81 -> buttons_out[7:0] is 0x00 after the second scan and 0x81 after the third.

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared types and default timing for the joypad scanner.
// Holds the scan FSM state enum, 25 MHz timing constants and a width helper.
package joypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    DONE
  } jp_state_e;

  localparam int JP_CLK_HZ      = 25_000_000;
  localparam int JP_NUM_PORTS   = 2;
  localparam int JP_NUM_BITS    = 8;
  localparam int JP_CLK_DIV     = 150;
  localparam int JP_SCAN_PERIOD = 416_666;

  // Bits needed to hold the value maxval (at least 1).
  function automatic int jp_cw(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/jp_port_shift.sv
// One controller port: 2-flop input synchroniser, button shift register,
// presence flag and (with JOYPAD_SCANNER_DEBOUNCE_EN) a two-scan agreement filter.
// Ports: clk_in, rst_n (sync, active-low), i_data (raw pad line),
//   i_sample (capture one bit), i_commit (final/tail sample of the scan),
//   o_buttons (active-high image), o_present (pad detected).
module jp_port_shift #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                i_data,
  input  logic                i_sample,
  input  logic                i_commit,
  output logic [NUM_BITS-1:0] o_buttons,
  output logic                o_present
);

  logic                r_sync1;
  logic                r_sync2;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS:0]   w_frame;
  logic [NUM_BITS-1:0] w_raw;
  logic                w_tail;

  // The second synchroniser flop is the last stage of the frame, so
  // at the tail sample the whole NUM_BITS+1 frame is visible at once.
  assign w_frame = {r_sync2, r_shift};
  assign w_raw   = w_frame[NUM_BITS-1:0];
  assign w_tail  = w_frame[NUM_BITS];

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_shift <= '0;
    end else begin
      r_sync1 <= i_data;
      r_sync2 <= r_sync1;
      if (i_sample) r_shift <= w_frame[NUM_BITS:1];
    end
  end

`ifdef JOYPAD_SCANNER_DEBOUNCE_EN
  logic [NUM_BITS-1:0] r_prev;

  // History starts as "all released" (raw ones).
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      o_buttons <= '0;
      o_present <= 1'b0;
      r_prev    <= '1;
    end else if (i_commit) begin
      o_present <= w_tail;
      r_prev    <= w_raw;
      if (!w_tail) o_buttons <= '0;
      else if (w_raw == r_prev) o_buttons <= ~w_raw;
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      o_buttons <= '0;
      o_present <= 1'b0;
    end else if (i_commit) begin
      o_present <= w_tail;
      o_buttons <= w_tail ? ~w_raw : '0;
    end
  end
`endif

endmodule

// File: rtl/joypad_scanner.sv
// Autonomous NES/SNES pad scanner: latch/clock strobes, per-port capture,
// parallel active-high button image. Optional macro JOYPAD_SCANNER_DEBOUNCE_EN.
// Ports: clk_in, rst_n (sync, active-low), scan_req_in, jp_data_in[NUM_PORTS],
//   jp_latch_out, jp_clk_out, buttons_out[NUM_PORTS*NUM_BITS],
//   present_out[NUM_PORTS], valid_out, busy_out.
module joypad_scanner
  import joypad_pkg::*;
#(
  parameter int NUM_PORTS   = JP_NUM_PORTS,
  parameter int NUM_BITS    = JP_NUM_BITS,
  parameter int CLK_DIV     = JP_CLK_DIV,
  parameter int SCAN_PERIOD = JP_SCAN_PERIOD
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          scan_req_in,
  input  logic [NUM_PORTS-1:0]          jp_data_in,
  output logic                          jp_latch_out,
  output logic                          jp_clk_out,
  output logic [NUM_PORTS*NUM_BITS-1:0] buttons_out,
  output logic [NUM_PORTS-1:0]          present_out,
  output logic                          valid_out,
  output logic                          busy_out
);

  localparam int DW = jp_cw(2 * CLK_DIV - 1);
  localparam int BW = jp_cw(NUM_BITS - 1);
  localparam int PW = jp_cw(SCAN_PERIOD);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
  localparam bit            AUTO     = (SCAN_PERIOD != 0);
  localparam logic [PW-1:0] RELOAD   =
    AUTO ? PW'(SCAN_PERIOD - 1) : '0;

  jp_state_e     r_state;
  logic [PW-1:0] r_period;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;

  logic w_start;
  logic w_sample;
  logic w_commit;

  assign w_start  = scan_req_in || (AUTO && (r_period == '0));
  assign w_sample = ((r_state == LATCH) || (r_state == SHIFT))
                    && (r_div == DIV_LAST);
  assign w_commit = (r_state == SHIFT) && (r_div == DIV_LAST)
                    && (r_bit == BIT_LAST);

  // The period counter runs in every state and saturates at zero, so
  // automatic starts are SCAN_PERIOD apart; if it expires mid-scan the
  // next scan begins as soon as the FSM is back in IDLE.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_period     <= '0;
      r_div        <= '0;
      r_bit        <= '0;
      jp_latch_out <= 1'b0;
      jp_clk_out   <= 1'b0;
      valid_out    <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (r_period != '0) r_period <= r_period - PW'(1);
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state      <= LATCH;
            r_period     <= RELOAD;
            r_div        <= '0;
            r_bit        <= '0;
            jp_latch_out <= 1'b1;
            busy_out     <= 1'b1;
          end
        end
        LATCH: begin
          if (r_div == DIV_LAST) begin
            r_div        <= '0;
            r_state      <= SHIFT;
            jp_latch_out <= 1'b0;
            jp_clk_out   <= 1'b1;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_bit == BIT_LAST) begin
              r_state   <= DONE;
              valid_out <= 1'b1;
            end else begin
              r_bit      <= r_bit + BW'(1);
              jp_clk_out <= 1'b1;
            end
          end else begin
            r_div <= r_div + DW'(1);
            if (r_div == DIV_HALF) jp_clk_out <= 1'b0;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          busy_out <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    jp_port_shift #(
      .NUM_BITS(NUM_BITS)
    ) u_port (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .i_data   (jp_data_in[p]),
      .i_sample (w_sample),
      .i_commit (w_commit),
      .o_buttons(buttons_out[p*NUM_BITS +: NUM_BITS]),
      .o_present(present_out[p])
    );
  end

endmodule
